// File: rtl/splash_painter.sv
// Splash-screen painter: raster sweep of the framebuffer with black/red fills or ROM images.
// Optional build macro TRANSPARENT_KEY_EN: image pixels equal to KEY are not plotted.
module splash_painter #(
    parameter int         WIDTH  = 160,
    parameter int         HEIGHT = 120,
    parameter logic [2:0] RED    = 3'b100,
    parameter logic [2:0] KEY    = 3'b000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wren,
    input  logic        showTitle,
    input  logic        drawBlack,
    input  logic        showGameOver,
    input  logic        flash,
    output logic [14:0] rom_addr,
    input  logic [2:0]  title_data,
    input  logic [2:0]  gameover_data,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;
    typedef enum logic [1:0] {MODE_BLACK, MODE_FLASH, MODE_TITLE, MODE_GAMEOVER} mode_t;

    state_t      state, state_next;
    mode_t       mode, req_mode;
    logic        req_valid;

    logic [7:0]  cx;
    logic [6:0]  cy;
    logic        last_px;
    logic [14:0] pixel_addr;

    logic        s1_valid;
    logic [7:0]  s1_x;
    logic [6:0]  s1_y;
    logic        plot_q;
    logic        done_pend;
    logic        done_q;

    logic        keyable;
    logic        keyed;

    always_comb begin
        req_valid = drawBlack | flash | showGameOver | showTitle;
        req_mode  = MODE_TITLE;
        if (drawBlack)
            req_mode = MODE_BLACK;
        else if (flash)
            req_mode = MODE_FLASH;
        else if (showGameOver)
            req_mode = MODE_GAMEOVER;
    end

    assign last_px    = (cx == 8'(WIDTH - 1)) && (cy == 7'(HEIGHT - 1));
    assign pixel_addr = 15'(int'(cy) * WIDTH + int'(cx));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (wren && req_valid) state_next = SWEEP;
            SWEEP:   if (!wren) state_next = IDLE;
                     else if (last_px) state_next = DRAIN;
            DRAIN:   state_next = wren ? DONE : IDLE;
            DONE:    if (!wren) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mode      <= MODE_BLACK;
            cx        <= '0;
            cy        <= '0;
            rom_addr  <= '0;
            s1_valid  <= 1'b0;
            s1_x      <= '0;
            s1_y      <= '0;
            x         <= '0;
            y         <= '0;
            plot_q    <= 1'b0;
            done_pend <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_next;
            // Output stage lines up with the ROM's one-cycle read latency.
            x         <= s1_x;
            y         <= s1_y;
            plot_q    <= s1_valid;
            s1_valid  <= 1'b0;
            done_pend <= (state == DRAIN) && wren;
            done_q    <= done_pend;
            case (state)
                IDLE: begin
                    cx <= '0;
                    cy <= '0;
                    if (wren && req_valid)
                        mode <= req_mode;
                end
                SWEEP: begin
                    // An abort edge must not launch a new pixel; only the one in flight completes.
                    if (wren) begin
                        rom_addr <= pixel_addr;
                        s1_x     <= cx;
                        s1_y     <= cy;
                        s1_valid <= 1'b1;
                        if (cx == 8'(WIDTH - 1)) begin
                            cx <= '0;
                            cy <= cy + 7'd1;
                        end else begin
                            cx <= cx + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        colour = '0;
        case (mode)
            MODE_BLACK:    colour = '0;
            MODE_FLASH:    colour = RED;
            MODE_TITLE:    colour = title_data;
            MODE_GAMEOVER: colour = gameover_data;
            default:       colour = '0;
        endcase
    end

`ifdef TRANSPARENT_KEY_EN
    assign keyable = (mode == MODE_TITLE) || (mode == MODE_GAMEOVER);
`else
    assign keyable = 1'b0;
`endif

    assign keyed = keyable && (colour == KEY);
    assign plot  = plot_q && !keyed;
    assign busy  = (state == SWEEP) || (state == DRAIN);
    assign done  = done_q;

endmodule

// File: tb/tb_splash_painter.sv
// Self-checking bench for splash_painter: randomized requests scored against a pixel-sequence model.
module tb_splash_painter;

    localparam int W = 160;
    localparam int H = 120;
    localparam int N = W * H;
    // wren driven in cycle c is sampled at the edge ending c; the first plot follows two edges later.
    localparam int FIRST_LAT = 3;

    localparam int M_BLACK    = 0;
    localparam int M_FLASH    = 1;
    localparam int M_TITLE    = 2;
    localparam int M_GAMEOVER = 3;

`ifdef TRANSPARENT_KEY_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wren = 1'b0;
    logic        showTitle = 1'b0;
    logic        drawBlack = 1'b0;
    logic        showGameOver = 1'b0;
    logic        flash = 1'b0;
    logic [14:0] rom_addr;
    logic [2:0]  title_data;
    logic [2:0]  gameover_data;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    splash_painter #(
        .WIDTH (W),
        .HEIGHT(H),
        .RED   (3'b100),
        .KEY   (3'b000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wren         (wren),
        .showTitle    (showTitle),
        .drawBlack    (drawBlack),
        .showGameOver (showGameOver),
        .flash        (flash),
        .rom_addr     (rom_addr),
        .title_data   (title_data),
        .gameover_data(gameover_data),
        .x            (x),
        .y            (y),
        .colour       (colour),
        .plot         (plot),
        .busy         (busy),
        .done         (done)
    );

    // Image ROMs with one-cycle read latency.
    always @(posedge clk) begin
        title_data    <= rom_addr[2:0];
        gameover_data <= rom_addr[0] ? {rom_addr[2:1], 1'b1} : 3'b000;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_mode(input bit b, input bit f, input bit g, input bit t);
        if (b) return M_BLACK;
        if (f) return M_FLASH;
        if (g) return M_GAMEOVER;
        if (t) return M_TITLE;
        return -1;
    endfunction

    function automatic int unsigned ref_colour(input int m, input int k);
        case (m)
            M_BLACK:    return 0;
            M_FLASH:    return 4;
            M_TITLE:    return k % 8;
            M_GAMEOVER: return (k % 2 == 1) ? ((k / 2) % 4) * 2 + 1 : 0;
            default:    return 0;
        endcase
    endfunction

    function automatic bit keyed(input int m, input int k);
        return KEY_EN && (m == M_TITLE || m == M_GAMEOVER) && (ref_colour(m, k) == 0);
    endfunction

    function automatic int next_plotted(input int m, input int k);
        int j = k;
        while (j < N && keyed(m, j)) j++;
        return j;
    endfunction

    function automatic int expected_count(input int m);
        int c = 0;
        for (int k = 0; k < N; k++)
            if (!keyed(m, k)) c++;
        return c;
    endfunction

    int          cyc = 0;
    int          exp_mode = M_BLACK;
    int          exp_k = 0;
    int          plots = 0;
    int          done_cnt = 0;
    int          first_cyc = -1;
    int          done_cyc = -1;
    int          start_cyc = 0;
    logic [14:0] prev_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (plot) begin
            check_eq("plot_in_range", exp_k < N, 1);
            check_eq("plot_xy", {x, y}, ((exp_k % W) << 7) | (exp_k / W));
            check_eq("plot_colour", colour, ref_colour(exp_mode, exp_k));
            check_eq("rom_addr_lead", prev_addr, exp_k);
            if (plots == 0) first_cyc = cyc;
            plots++;
            exp_k = next_plotted(exp_mode, exp_k + 1);
        end
        if (done) begin
            if (done_cnt == 0) done_cyc = cyc;
            done_cnt++;
        end
        prev_addr = rom_addr;
    end

    task automatic start_sweep(input bit b, input bit f, input bit g, input bit t);
        @(posedge clk); #1;
        drawBlack    = b;
        flash        = f;
        showGameOver = g;
        showTitle    = t;
        wren         = 1'b1;
        start_cyc    = cyc;
        exp_mode     = ref_mode(b, f, g, t);
        exp_k        = next_plotted(exp_mode, 0);
        plots        = 0;
        done_cnt     = 0;
        first_cyc    = -1;
        done_cyc     = -1;
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        while (done_cnt == 0 && t < budget) begin
            @(negedge clk); #1;
            t++;
        end
        check_eq("done_within_budget", done_cnt != 0, 1);
    endtask

    task automatic finish_full();
        int n_exp = expected_count(exp_mode);
        wait_done(N + 100);
        check_eq("plot_count", plots, n_exp);
        check_eq("sweep_coverage", exp_k, N);
        check_eq("first_plot_latency", first_cyc - start_cyc, FIRST_LAT);
        check_eq("done_latency", done_cyc - start_cyc, N + FIRST_LAT);
        repeat (50) @(negedge clk);
        #1;
        check_eq("done_single_pulse", done_cnt, 1);
        check_eq("no_resweep_while_held", plots, n_exp);
        check_eq("busy_after_done", busy, 0);
    endtask

    initial begin
        int unsigned r;
        int          p0;
        int          t;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_plot", plot, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_x", x, 0);
        check_eq("reset_y", y, 0);
        check_eq("reset_colour", colour, 0);
        check_eq("reset_rom_addr", rom_addr, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Request with no select must be ignored.
        wren = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check_eq("noselect_busy", busy, 0);
        check_eq("noselect_plots", plots, 0);
        wren = 1'b0;

        // Reset in the middle of a black sweep.
        start_sweep(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (100) @(posedge clk);
        #1;
        rst  = 1'b1;
        wren = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        check_eq("midreset_plot", plot, 0);
        check_eq("midreset_x", x, 0);
        check_eq("midreset_y", y, 0);
        check_eq("midreset_busy", busy, 0);
        p0 = plots;
        repeat (20) @(negedge clk);
        #1;
        check_eq("midreset_no_plots", plots, p0);
        check_eq("midreset_no_done", done_cnt, 0);

        // Full black sweep; lower-priority selects randomly also high.
        r = $urandom;
        start_sweep(1'b1, r[0], r[1], r[2]);
        finish_full();

        // Re-arm, flash over title, switch to black mid-sweep.
        @(posedge clk); #1;
        wren = 1'b0;
        r = $urandom;
        start_sweep(1'b0, 1'b1, r[0], 1'b1);
        repeat ($urandom_range(1000, 15000)) @(posedge clk);
        #1;
        drawBlack = 1'b1;
        flash     = r[1];
        finish_full();

        // Title sweep aborted after 500 plots.
        @(posedge clk); #1;
        wren = 1'b0;
        start_sweep(1'b0, 1'b0, 1'b0, 1'b1);
        t = 0;
        while (plots < 500 && t < 3000) begin
            @(negedge clk); #1;
            t++;
        end
        check_eq("abort_reached_500", plots >= 500, 1);
        @(posedge clk); #1;
        wren = 1'b0;
        @(negedge clk); #1;
        p0 = plots;
        repeat (6) @(negedge clk);
        #1;
        check_eq("abort_tail_le1", (plots - p0) <= 1, 1);
        check_eq("abort_no_done", done_cnt, 0);
        check_eq("abort_busy", busy, 0);

        // Game-over sweep with random select noise mid-sweep.
        r = $urandom;
        start_sweep(1'b0, 1'b0, 1'b1, r[0]);
        repeat ($urandom_range(500, 15000)) @(posedge clk);
        #1;
        flash     = 1'b1;
        drawBlack = r[1];
        finish_full();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
